cpu7_ifu_imd_pipe: RTL and testbench
====================================

# cpu7_ifu_imd_pipe

Parametrised, pipelined immediate/branch-offset generator for the decode→execute boundary of the cpu7 IFU. It decodes immediates for `LANES` instructions per cycle and extends them to `GRLEN`. It also computes each lane's branch target (`pc + offset`). Results are registered into an E-stage holding register that honours execute-side stall and pipeline flush. It replaces the single-lane, purely combinational immediate decoder on the ifu→exu path.

## Interface
- `GRLEN`, default 32: datapath width, 32 or 64. All immediates and offsets are sign- or zero-extended to this width.
- `LANES`, default 1: decode lanes per cycle, 1 or 2. Lane k occupies slice k of every packed bus.
- `OP_W`, default `` `LSOC1K_DECODE_RES_BIT ``: width of one decoded-op vector.
- `clk`  in  1  core clock; all state is updated on its rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `ifu_imd_vld_d`  in  LANES  lane k holds a valid instruction in D.
- `ifu_imd_inst_d`  in  32*LANES  raw instruction words.
- `ifu_imd_op_d`  in  OP_W*LANES  decoded-op vectors.
- `ifu_imd_pc_d`  in  GRLEN*LANES  instruction PCs.
- `imd_ifu_ready_d`  out  1  D-stage contents are accepted at this edge.
- `exu_imd_stall_e`  in  1  execute stage cannot take the E-stage contents.
- `exu_imd_flush`  in  1  kill all D and E contents (branch mispredict or exception).
- `imd_exu_vld_e`  out  LANES  lane k of the E register is valid.
- `imd_exu_imm_shifted_e`  out  GRLEN*LANES  extended, shifted immediate.
- `imd_exu_c_e`  out  GRLEN*LANES  ALU auxiliary operand.
- `imd_exu_br_offs_e`  out  GRLEN*LANES  branch offset, in bytes.
- `imd_exu_br_target_e`  out  GRLEN*LANES  `pc + br_offs`, modulo 2^GRLEN.

## Operation
- **Per-lane combinational decode in D** (identical for every lane):
  - Field extraction uses the `GET_*` macros: i5, i6, i12, i14, i16, i20, SA, MSLSBD, offset16, offset21, offset26.
  - Base immediate, priority I5 > I12 > I14 > I16 > I20, else 0.
  - I5 selects i6 zero-extended when `DOUBLE_WORD`, otherwise i5 zero-extended.
  - I12 is zero-extended when `UNSIGN`, otherwise sign-extended.
  - I14, I16 and I20 are always sign-extended. All extension is to GRLEN.
- **Shift:** the `IMM_SHIFT` field selects one of <<2, <<12, <<16, <<18 or none. It is a logical left shift within GRLEN, and high bits are discarded. When GRLEN=64, the <<12 and <<16 results are sign-extended from bit 31 (LU12I semantics).
- **C operand**, first match wins:
  - ALU_CODE is COUNT_L or COUNT_T: `{0…, !UNSIGN}`.
  - `SA` is set or ALU_CODE is ALIGN: SA zero-extended.
  - ALU_CODE is EXT or INS: MSLSBD zero-extended.
  - Otherwise: the unshifted base immediate.
- **Branch offset:**
  - RD_READ: offset16 sign-extended, then <<2.
  - Else HIGH_TARGET: offset26 sign-extended, then <<2.
  - Else: offset21 sign-extended, then <<2.
- **Branch target:** target = pc + offset, one GRLEN adder per lane, carry out dropped.
- **E register:** one entry per lane holds vld, imm, c, offs and target.
- **Register update priority:** reset > flush > stall > load.
  - reset or flush: every `vld_e` bit clears to 0 next cycle. Data registers may keep stale values.
  - stall (and no flush): the E register holds all fields.
  - Otherwise: load every lane from D. `vld_e[k] = vld_d[k]`, and data is loaded even when invalid.
- **Ready:** `imd_ifu_ready_d = !exu_imd_stall_e || !(|imd_exu_vld_e)`. A stalled but empty E register still accepts D, so a bubble is absorbed.
- Lanes are independent. An invalid lane 0 does not block lane 1, and lanes are not compacted.

## Timing
- Latency: D inputs sampled at edge n appear on the E outputs after edge n (1 cycle).
- Reset values: `imd_exu_vld_e` = 0 and `imd_ifu_ready_d` = 1. All data outputs are 0 after reset, because the data registers are also reset.
- Stall with a valid E entry: outputs are bit-stable every cycle the stall is held, and ready = 0. Resuming loads the D contents present on the edge where the stall drops.
- Flush in the same cycle as stall: flush wins, and vld_e = 0 next cycle. ready is computed from the pre-flush vld_e and is ignored by the IFU during a flush.
- Flush in the same cycle as new D data: the D data is dropped and is not loaded.
- Reset asserted mid-stall: vld_e = 0 next cycle, and ready returns to 1.
- Target wraps: pc = 0xFFFFFFFC with offset +8 gives 0x00000004 (GRLEN=32).
- There are no combinational paths from `exu_imd_stall_e` or `exu_imd_flush` to the data outputs. The only stall-dependent combinational path is the one to `ready`.

## Test plan
1. **Basic load.** GRLEN=32, LANES=1, op I12 signed, i12=0xFFF, vld=1 → next cycle vld_e=1 and imm=0xFFFFFFFF. The same op with UNSIGN gives imm=0x00000FFF.
2. **Shift.** op I20 with IMM_SHIFT_12, i20=0x12345 → imm=0x12345000. With GRLEN=64 and i20=0x80000, the result is imm=0xFFFFFFFF80000000.
3. **Branch target.** RD_READ with offset16=0x8000 and pc=0x1C000000 → br_offs=0xFFFE0000 and target=0x1BFE0000. HIGH_TARGET with offset26=0x0000001 → offs=4, target=pc+4.
4. **Stall/hold.** Load A, then assert stall for 3 cycles while D presents B → E holds A and ready=0 throughout. On stall release, B appears next cycle.
5. **Flush priority.** vld_e=1, stall=1 and flush=1 in the same cycle → vld_e=0 next cycle and ready=1. With D valid during the flush, it is not loaded.
6. **Dual lane (LANES=2).** vld_d=2'b10 with lane 1 COUNT_T, UNSIGN=0 → vld_e=2'b10, lane 1 c=0x00000001, and lane 0 is ignored.

Source files
------------

// File: rtl/cpu7_ifu_imd_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu7_ifu_imd_pipe_if
// Purpose  : D-stage inputs, E-stage outputs and execute-side control of the
//            cpu7 IFU immediate/branch-offset pipe, bundled as one interface.
//            The IFU/EXU side uses the master modport and the pipe uses the
//            slave modport.
// Revision : 1.0  initial release
// ============================================================================

`ifndef LSOC1K_DECODE_RES_BIT
`define LSOC1K_DECODE_RES_BIT 17
`endif

interface cpu7_ifu_imd_pipe_if #(
  parameter int GRLEN = 32,
  parameter int LANES = 1,
  parameter int OP_W  = `LSOC1K_DECODE_RES_BIT
);
  // D-stage instruction bundle
  logic [LANES-1:0]       ifu_imd_vld_d;
  logic [32*LANES-1:0]    ifu_imd_inst_d;
  logic [OP_W*LANES-1:0]  ifu_imd_op_d;
  logic [GRLEN*LANES-1:0] ifu_imd_pc_d;
  logic                   imd_ifu_ready_d;

  // Execute-side control
  logic                   exu_imd_stall_e;
  logic                   exu_imd_flush;

  // E-stage results
  logic [LANES-1:0]       imd_exu_vld_e;
  logic [GRLEN*LANES-1:0] imd_exu_imm_shifted_e;
  logic [GRLEN*LANES-1:0] imd_exu_c_e;
  logic [GRLEN*LANES-1:0] imd_exu_br_offs_e;
  logic [GRLEN*LANES-1:0] imd_exu_br_target_e;

  modport master (
    output ifu_imd_vld_d, ifu_imd_inst_d, ifu_imd_op_d, ifu_imd_pc_d,
    output exu_imd_stall_e, exu_imd_flush,
    input  imd_ifu_ready_d,
    input  imd_exu_vld_e, imd_exu_imm_shifted_e, imd_exu_c_e,
    input  imd_exu_br_offs_e, imd_exu_br_target_e
  );

  modport slave (
    input  ifu_imd_vld_d, ifu_imd_inst_d, ifu_imd_op_d, ifu_imd_pc_d,
    input  exu_imd_stall_e, exu_imd_flush,
    output imd_ifu_ready_d,
    output imd_exu_vld_e, imd_exu_imm_shifted_e, imd_exu_c_e,
    output imd_exu_br_offs_e, imd_exu_br_target_e
  );
endinterface

`default_nettype wire

// File: rtl/cpu7_ifu_imd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cpu7_ifu_imd_pipe
// Purpose  : Per-lane immediate decode, shift, ALU auxiliary operand, branch
//            offset and branch target generation in D, registered into an
//            E-stage holding register with stall and flush control.
// Revision : 1.0  initial release
// ============================================================================

`ifndef LSOC1K_DECODE_RES_BIT
`define LSOC1K_DECODE_RES_BIT 17
`endif

// Decoded-op vector layout: single-bit flags, then the shift selector and the
// ALU code sub-fields.
`ifndef CPU7_IMD_DECODE_DEFS
`define CPU7_IMD_DECODE_DEFS
`define LSOC1K_I5          0
`define LSOC1K_I12         1
`define LSOC1K_I14         2
`define LSOC1K_I16         3
`define LSOC1K_I20         4
`define LSOC1K_DOUBLE_WORD 5
`define LSOC1K_UNSIGN      6
`define LSOC1K_SA          7
`define LSOC1K_RD_READ     8
`define LSOC1K_HIGH_TARGET 9
`define LSOC1K_IMM_SHIFT   12:10
`define LSOC1K_ALU_CODE    16:13

// IMM_SHIFT encodings
`define IMM_SHIFT_NONE 3'd0
`define IMM_SHIFT_2    3'd1
`define IMM_SHIFT_12   3'd2
`define IMM_SHIFT_16   3'd3
`define IMM_SHIFT_18   3'd4

// ALU_CODE encodings that affect the C operand
`define ALU_COUNT_L 4'd1
`define ALU_COUNT_T 4'd2
`define ALU_ALIGN   4'd3
`define ALU_EXT     4'd4
`define ALU_INS     4'd5

// Instruction field extraction
`define GET_I5(x)       x[14:10]
`define GET_I6(x)       x[15:10]
`define GET_I12(x)      x[21:10]
`define GET_I14(x)      x[23:10]
`define GET_I16(x)      x[25:10]
`define GET_I20(x)      x[24:5]
`define GET_SA(x)       x[17:15]
`define GET_MSLSBD(x)   x[21:10]
`define GET_OFFSET16(x) x[25:10]
`define GET_OFFSET21(x) {x[4:0], x[25:10]}
`define GET_OFFSET26(x) {x[9:0], x[25:10]}
`endif

module cpu7_ifu_imd_pipe #(
  parameter int GRLEN = 32,
  parameter int LANES = 1,
  parameter int OP_W  = `LSOC1K_DECODE_RES_BIT
) (
  input  logic                    clk,
  input  logic                    reset,
  cpu7_ifu_imd_pipe_if.slave      imd_io
);

  // D-stage results, packed lane by lane
  logic [GRLEN*LANES-1:0] imm_d;
  logic [GRLEN*LANES-1:0] c_d;
  logic [GRLEN*LANES-1:0] offs_d;
  logic [GRLEN*LANES-1:0] target_d;

  // E-stage holding register
  logic [LANES-1:0]       vld_e_q;
  logic [GRLEN*LANES-1:0] imm_e_q;
  logic [GRLEN*LANES-1:0] c_e_q;
  logic [GRLEN*LANES-1:0] offs_e_q;
  logic [GRLEN*LANES-1:0] target_e_q;

  logic                   ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [31:0]       inst;
    logic [OP_W-1:0]   op;
    logic [GRLEN-1:0]  pc;
    logic [2:0]        sh_sel;
    logic [3:0]        alu;
    logic [GRLEN-1:0]  base;
    logic [GRLEN-1:0]  sh_raw;
    logic [GRLEN-1:0]  shifted;
    logic [GRLEN-1:0]  c_opnd;
    logic [GRLEN-1:0]  offs;
    logic              lane_unused;

    assign inst        = imd_io.ifu_imd_inst_d[32*k +: 32];
    assign op          = imd_io.ifu_imd_op_d[OP_W*k +: OP_W];
    assign pc          = imd_io.ifu_imd_pc_d[GRLEN*k +: GRLEN];
    assign sh_sel      = op[`LSOC1K_IMM_SHIFT];
    assign alu         = op[`LSOC1K_ALU_CODE];
    // The opcode bits are fully decoded upstream into op.
    assign lane_unused = ^inst[31:26];

    // Base immediate selection and extension, fixed priority I5 first
    always_comb begin
      base = '0;
      if (op[`LSOC1K_I5]) begin
        if (op[`LSOC1K_DOUBLE_WORD]) base = GRLEN'(`GET_I6(inst));
        else                         base = GRLEN'(`GET_I5(inst));
      end else if (op[`LSOC1K_I12]) begin
        if (op[`LSOC1K_UNSIGN])      base = GRLEN'(`GET_I12(inst));
        else                         base = GRLEN'($signed(`GET_I12(inst)));
      end else if (op[`LSOC1K_I14]) begin
        base = GRLEN'($signed(`GET_I14(inst)));
      end else if (op[`LSOC1K_I16]) begin
        base = GRLEN'($signed(`GET_I16(inst)));
      end else if (op[`LSOC1K_I20]) begin
        base = GRLEN'($signed(`GET_I20(inst)));
      end
    end

    // Shift within GRLEN; <<12 and <<16 re-extend from bit 31 so a 64-bit
    // LU12I-style result is the sign-extended 32-bit value.
    always_comb begin
      sh_raw = base;
      case (sh_sel)
        `IMM_SHIFT_2:  sh_raw = base << 2;
        `IMM_SHIFT_12: sh_raw = base << 12;
        `IMM_SHIFT_16: sh_raw = base << 16;
        `IMM_SHIFT_18: sh_raw = base << 18;
        default:       sh_raw = base;
      endcase
      shifted = sh_raw;
      if (sh_sel == `IMM_SHIFT_12 || sh_sel == `IMM_SHIFT_16)
        shifted = GRLEN'($signed(sh_raw[31:0]));
    end

    // ALU auxiliary operand, first match wins
    always_comb begin
      c_opnd = base;
      if (alu == `ALU_COUNT_L || alu == `ALU_COUNT_T)
        c_opnd = GRLEN'(!op[`LSOC1K_UNSIGN]);
      else if (op[`LSOC1K_SA] || alu == `ALU_ALIGN)
        c_opnd = GRLEN'(`GET_SA(inst));
      else if (alu == `ALU_EXT || alu == `ALU_INS)
        c_opnd = GRLEN'(`GET_MSLSBD(inst));
    end

    // Branch offset in bytes: word offset sign-extended and scaled by 4
    always_comb begin
      offs = GRLEN'($signed({`GET_OFFSET21(inst), 2'b00}));
      if (op[`LSOC1K_RD_READ])
        offs = GRLEN'($signed({`GET_OFFSET16(inst), 2'b00}));
      else if (op[`LSOC1K_HIGH_TARGET])
        offs = GRLEN'($signed({`GET_OFFSET26(inst), 2'b00}));
    end

    assign imm_d[GRLEN*k +: GRLEN]    = shifted;
    assign c_d[GRLEN*k +: GRLEN]      = c_opnd;
    assign offs_d[GRLEN*k +: GRLEN]   = offs;
    assign target_d[GRLEN*k +: GRLEN] = pc + offs;
  end

  // A stalled but empty E register still accepts D, absorbing the bubble.
  assign ready = !imd_io.exu_imd_stall_e || !(|vld_e_q);

  // E register: reset clears everything, flush kills valids, else load when ready
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_e_q    <= '0;
      imm_e_q    <= '0;
      c_e_q      <= '0;
      offs_e_q   <= '0;
      target_e_q <= '0;
    end else if (imd_io.exu_imd_flush) begin
      vld_e_q    <= '0;
    end else if (ready) begin
      vld_e_q    <= imd_io.ifu_imd_vld_d;
      imm_e_q    <= imm_d;
      c_e_q      <= c_d;
      offs_e_q   <= offs_d;
      target_e_q <= target_d;
    end
  end

  assign imd_io.imd_ifu_ready_d       = ready;
  assign imd_io.imd_exu_vld_e         = vld_e_q;
  assign imd_io.imd_exu_imm_shifted_e = imm_e_q;
  assign imd_io.imd_exu_c_e           = c_e_q;
  assign imd_io.imd_exu_br_offs_e     = offs_e_q;
  assign imd_io.imd_exu_br_target_e   = target_e_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu7_ifu_imd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu7_ifu_imd_pipe
// Purpose  : Directed self-checking bench for cpu7_ifu_imd_pipe: a 32-bit
//            dual-lane instance and a 64-bit single-lane instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu7_ifu_imd_pipe;

  // Op-vector encodings, built by hand from the decode field layout
  localparam logic [16:0] OP_I5     = 17'h00001;
  localparam logic [16:0] OP_I12    = 17'h00002;
  localparam logic [16:0] OP_I20    = 17'h00010;
  localparam logic [16:0] OP_DW     = 17'h00020;
  localparam logic [16:0] OP_UNSIGN = 17'h00040;
  localparam logic [16:0] OP_SA     = 17'h00080;
  localparam logic [16:0] OP_RDREAD = 17'h00100;
  localparam logic [16:0] OP_HIGHT  = 17'h00200;
  localparam logic [16:0] OP_SH12   = 17'h00800;
  localparam logic [16:0] OP_SH16   = 17'h00C00;
  localparam logic [16:0] OP_CNT_T  = 17'h04000;
  localparam logic [16:0] OP_EXT    = 17'h08000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cpu7_ifu_imd_pipe_if #(.GRLEN(32), .LANES(2), .OP_W(17)) ifa ();
  cpu7_ifu_imd_pipe_if #(.GRLEN(64), .LANES(1), .OP_W(17)) ifb ();

  cpu7_ifu_imd_pipe #(.GRLEN(32), .LANES(2), .OP_W(17)) u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .imd_io (ifa)
  );

  cpu7_ifu_imd_pipe #(.GRLEN(64), .LANES(1), .OP_W(17)) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .imd_io (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, landing just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive lane 0 of the 32-bit instance
  task automatic lane0(input logic [16:0] op, input logic [31:0] inst, input logic [31:0] pc);
    ifa.ifu_imd_op_d[16:0]   = op;
    ifa.ifu_imd_inst_d[31:0] = inst;
    ifa.ifu_imd_pc_d[31:0]   = pc;
  endtask

  // Drive lane 1 of the 32-bit instance
  task automatic lane1(input logic [16:0] op, input logic [31:0] inst, input logic [31:0] pc);
    ifa.ifu_imd_op_d[33:17]   = op;
    ifa.ifu_imd_inst_d[63:32] = inst;
    ifa.ifu_imd_pc_d[63:32]   = pc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ifa.ifu_imd_vld_d   = '0;
    ifa.ifu_imd_inst_d  = '0;
    ifa.ifu_imd_op_d    = '0;
    ifa.ifu_imd_pc_d    = '0;
    ifa.exu_imd_stall_e = 1'b0;
    ifa.exu_imd_flush   = 1'b0;
    ifb.ifu_imd_vld_d   = '0;
    ifb.ifu_imd_inst_d  = '0;
    ifb.ifu_imd_op_d    = '0;
    ifb.ifu_imd_pc_d    = '0;
    ifb.exu_imd_stall_e = 1'b0;
    ifb.exu_imd_flush   = 1'b0;
    step();
    step();

    // Reset state
    check_val("rst_vld_a",   64'(ifa.imd_exu_vld_e), 64'h0);
    check_val("rst_ready_a", 64'(ifa.imd_ifu_ready_d), 64'h1);
    check_val("rst_imm_a",   64'(ifa.imd_exu_imm_shifted_e), 64'h0);
    check_val("rst_tgt_a",   64'(ifa.imd_exu_br_target_e), 64'h0);
    check_val("rst_vld_b",   64'(ifb.imd_exu_vld_e), 64'h0);
    reset = 1'b0;

    // Basic load: I12 signed / unsigned
    ifa.ifu_imd_vld_d = 2'b01;
    lane0(OP_I12, 32'h003F_FC00, 32'h0000_1000);
    lane1(17'h0, 32'h0, 32'h0);
    step();
    check_val("i12s_vld",  64'(ifa.imd_exu_vld_e), 64'h1);
    check_val("i12s_imm",  64'(ifa.imd_exu_imm_shifted_e[31:0]), 64'hFFFF_FFFF);
    check_val("i12s_c",    64'(ifa.imd_exu_c_e[31:0]), 64'hFFFF_FFFF);
    check_val("i12s_offs", 64'(ifa.imd_exu_br_offs_e[31:0]), 64'h0000_3FFC);
    check_val("i12s_tgt",  64'(ifa.imd_exu_br_target_e[31:0]), 64'h0000_4FFC);
    lane0(OP_I12 | OP_UNSIGN, 32'h003F_FC00, 32'h0000_1000);
    step();
    check_val("i12u_imm",  64'(ifa.imd_exu_imm_shifted_e[31:0]), 64'h0000_0FFF);

    // Shift and I5 / DOUBLE_WORD selection
    lane0(OP_I20 | OP_SH12, 32'h0024_68A0, 32'h0);
    step();
    check_val("i20sh12_imm", 64'(ifa.imd_exu_imm_shifted_e[31:0]), 64'h1234_5000);
    check_val("i20sh12_c",   64'(ifa.imd_exu_c_e[31:0]), 64'h0001_2345);
    lane0(OP_I5, 32'h0000_FC00, 32'h0);
    step();
    check_val("i5_imm",    64'(ifa.imd_exu_imm_shifted_e[31:0]), 64'h0000_001F);
    lane0(OP_I5 | OP_DW, 32'h0000_FC00, 32'h0);
    step();
    check_val("i5dw_imm",  64'(ifa.imd_exu_imm_shifted_e[31:0]), 64'h0000_003F);

    // Branch offsets and targets
    lane0(OP_RDREAD, 32'h0200_0000, 32'h1C00_0000);
    step();
    check_val("rd_offs",   64'(ifa.imd_exu_br_offs_e[31:0]), 64'hFFFE_0000);
    check_val("rd_tgt",    64'(ifa.imd_exu_br_target_e[31:0]), 64'h1BFE_0000);
    lane0(OP_HIGHT, 32'h0000_0400, 32'h1C00_0000);
    step();
    check_val("ht_offs",   64'(ifa.imd_exu_br_offs_e[31:0]), 64'h0000_0004);
    check_val("ht_tgt",    64'(ifa.imd_exu_br_target_e[31:0]), 64'h1C00_0004);
    lane0(OP_HIGHT, 32'h0000_0800, 32'hFFFF_FFFC);
    step();
    check_val("wrap_tgt",  64'(ifa.imd_exu_br_target_e[31:0]), 64'h0000_0004);
    lane0(OP_HIGHT, 32'h0000_0200, 32'h0);
    step();
    check_val("ht_neg_offs", 64'(ifa.imd_exu_br_offs_e[31:0]), 64'hF800_0000);
    lane0(17'h0, 32'h0000_0010, 32'h0);
    step();
    check_val("o21_neg_offs", 64'(ifa.imd_exu_br_offs_e[31:0]), 64'hFFC0_0000);

    // 64-bit datapath: LU12I-style sign extension from bit 31
    ifb.ifu_imd_vld_d  = 1'b1;
    ifb.ifu_imd_op_d   = OP_I20 | OP_SH12;
    ifb.ifu_imd_inst_d = 32'h0100_0000;
    step();
    check_val("g64_sh12_imm", ifb.imd_exu_imm_shifted_e, 64'hFFFF_FFFF_8000_0000);
    ifb.ifu_imd_op_d   = OP_I20 | OP_SH16;
    ifb.ifu_imd_inst_d = 32'h00FF_FFE0;
    step();
    check_val("g64_sh16_imm", ifb.imd_exu_imm_shifted_e, 64'hFFFF_FFFF_FFFF_0000);
    ifb.ifu_imd_vld_d  = 1'b0;

    // Stall/hold: A held for three cycles while D presents B
    lane0(OP_I12, 32'h003F_FC00, 32'h0);
    step();
    ifa.exu_imd_stall_e = 1'b1;
    lane0(OP_I12 | OP_UNSIGN, 32'h003F_FC00, 32'h0);
    #1;
    check_val("stall_ready0", 64'(ifa.imd_ifu_ready_d), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_imm",   64'(ifa.imd_exu_imm_shifted_e[31:0]), 64'hFFFF_FFFF);
      check_val("stall_vld",   64'(ifa.imd_exu_vld_e), 64'h1);
      check_val("stall_ready", 64'(ifa.imd_ifu_ready_d), 64'h0);
    end
    ifa.exu_imd_stall_e = 1'b0;
    #1;
    check_val("resume_ready", 64'(ifa.imd_ifu_ready_d), 64'h1);
    step();
    check_val("resume_imm", 64'(ifa.imd_exu_imm_shifted_e[31:0]), 64'h0000_0FFF);
    check_val("resume_vld", 64'(ifa.imd_exu_vld_e), 64'h1);

    // Flush wins over stall; D valid during flush is dropped
    ifa.exu_imd_stall_e = 1'b1;
    ifa.exu_imd_flush   = 1'b1;
    lane0(OP_I12, 32'h003F_FC00, 32'h0);
    step();
    check_val("flush_vld",   64'(ifa.imd_exu_vld_e), 64'h0);
    check_val("flush_ready", 64'(ifa.imd_ifu_ready_d), 64'h1);
    ifa.exu_imd_stall_e = 1'b0;
    step();
    check_val("flush_nostall_vld", 64'(ifa.imd_exu_vld_e), 64'h0);
    ifa.exu_imd_flush = 1'b0;

    // Dual lane: lane 0 invalid, lane 1 COUNT_T with a branch
    ifa.ifu_imd_vld_d = 2'b10;
    lane0(OP_I12, 32'h003F_FC00, 32'h0);
    lane1(OP_CNT_T | OP_HIGHT, 32'h0000_0400, 32'h0000_2000);
    step();
    check_val("dl_vld",  64'(ifa.imd_exu_vld_e), 64'h2);
    check_val("dl_c1",   64'(ifa.imd_exu_c_e[63:32]), 64'h1);
    check_val("dl_tgt1", 64'(ifa.imd_exu_br_target_e[63:32]), 64'h0000_2004);
    lane1(OP_CNT_T | OP_UNSIGN, 32'h0, 32'h0);
    step();
    check_val("dl_c1_uns", 64'(ifa.imd_exu_c_e[63:32]), 64'h0);
    lane1(OP_SA, 32'h0002_8000, 32'h0);
    step();
    check_val("dl_c1_sa",  64'(ifa.imd_exu_c_e[63:32]), 64'h5);
    lane1(OP_EXT, 32'h002A_F000, 32'h0);
    step();
    check_val("dl_c1_ext", 64'(ifa.imd_exu_c_e[63:32]), 64'hABC);

    // Reset asserted mid-stall
    ifa.ifu_imd_vld_d = 2'b01;
    step();
    ifa.exu_imd_stall_e = 1'b1;
    step();
    check_val("rstst_hold_vld", 64'(ifa.imd_exu_vld_e), 64'h1);
    reset = 1'b1;
    step();
    check_val("rstst_vld",   64'(ifa.imd_exu_vld_e), 64'h0);
    check_val("rstst_ready", 64'(ifa.imd_ifu_ready_d), 64'h1);
    reset = 1'b0;
    ifa.exu_imd_stall_e = 1'b0;
    ifa.ifu_imd_vld_d   = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
